// File: rtl/vector_register_bank.sv
// vector_register_bank: lane-masked dual write-back register file with same-cycle
// write-to-read bypass and per-register busy scoreboard for RAW hazard stalls.
module vector_register_bank #(
   parameter int INDEX_SIZE = 4,
   parameter int WIDTH      = 32,
   parameter int LANES      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [INDEX_SIZE-1:0]       ra,
   input  logic [INDEX_SIZE-1:0]       rb,
   input  logic [INDEX_SIZE-1:0]       rc,
   output logic [LANES*WIDTH-1:0]      rd1,
   output logic [LANES*WIDTH-1:0]      rd2,
   output logic [LANES*WIDTH-1:0]      rd3,
   input  logic                        wa_en,
   input  logic [INDEX_SIZE-1:0]       wa_addr,
   input  logic [LANES-1:0]            wa_mask,
   input  logic [LANES*WIDTH-1:0]      wa_data,
   input  logic                        wb_en,
   input  logic [INDEX_SIZE-1:0]       wb_addr,
   input  logic [LANES-1:0]            wb_mask,
   input  logic [LANES*WIDTH-1:0]      wb_data,
   input  logic                        iss_en,
   input  logic [INDEX_SIZE-1:0]       iss_rd,
   output logic                        src_busy,
   output logic [(2**INDEX_SIZE)-1:0]  busy
);
   localparam int N  = 2**INDEX_SIZE;
   localparam int RW = LANES*WIDTH;

   logic [RW-1:0] regs_q [N];
   logic [RW-1:0] regs_d [N];
   logic [N-1:0]  busy_q, busy_d;

   // Overlay this cycle's writes onto stored data; port B is applied last so it wins.
   function automatic logic [RW-1:0] merge(input logic [INDEX_SIZE-1:0] a, input logic [RW-1:0] s);
      logic [RW-1:0] r;
      r = s;
      for (int k = 0; k < LANES; k++) begin
         if (a != '0 && wa_en && wa_addr == a && wa_mask[k]) r[k*WIDTH +: WIDTH] = wa_data[k*WIDTH +: WIDTH];
         if (a != '0 && wb_en && wb_addr == a && wb_mask[k]) r[k*WIDTH +: WIDTH] = wb_data[k*WIDTH +: WIDTH];
      end
      return r;
   endfunction

   function automatic logic written(input logic [INDEX_SIZE-1:0] a);
      return (wa_en && wa_addr == a) || (wb_en && wb_addr == a);
   endfunction

   function automatic logic pending(input logic [INDEX_SIZE-1:0] a);
      return a != '0 && busy_q[a] && !written(a);
   endfunction

   always_comb begin
      for (int i = 0; i < N; i++) begin
         regs_d[i] = (i == 0) ? '0 : merge(INDEX_SIZE'(i), regs_q[i]);
         busy_d[i] = (i != 0) && ((iss_en && iss_rd == INDEX_SIZE'(i)) || (busy_q[i] && !written(INDEX_SIZE'(i))));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) regs_q[i] <= '0;
         busy_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) regs_q[i] <= regs_d[i];
         busy_q <= busy_d;
      end
   end

   assign rd1      = rst ? merge(ra, regs_q[ra]) : '0;
   assign rd2      = rst ? merge(rb, regs_q[rb]) : '0;
   assign rd3      = rst ? merge(rc, regs_q[rc]) : '0;
   assign src_busy = rst && (pending(ra) || pending(rb) || pending(rc));
   assign busy     = busy_q;
endmodule

// File: tb/tb_vector_register_bank.sv
// tb_vector_register_bank: randomized and directed checks against a lane-level
// reference model of the register bank and its scoreboard.
module tb_vector_register_bank;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   ra, rb, rc, wa_addr, wb_addr, iss_rd;
   logic [3:0]   wa_mask, wb_mask;
   logic [127:0] wa_data, wb_data, rd1, rd2, rd3;
   logic         wa_en, wb_en, iss_en, src_busy;
   logic [15:0]  busy;
   logic [31:0]  mem [16][4];
   bit           mbusy [16];
   bit           started = 1'b0;
   int           n_chk = 0, n_fail = 0;

   vector_register_bank dut (
      .clk(clk), .rst(rst), .ra(ra), .rb(rb), .rc(rc), .rd1(rd1), .rd2(rd2), .rd3(rd3),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_mask(wa_mask), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_mask(wb_mask), .wb_data(wb_data),
      .iss_en(iss_en), .iss_rd(iss_rd), .src_busy(src_busy), .busy(busy)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: value seen by a reader, lane by lane.
   function automatic logic [127:0] exp_rd(input logic [3:0] a);
      logic [127:0] r;
      r = '0;
      if (rst && a != 0)
         for (int l = 0; l < 4; l++) begin
            if (wb_en && wb_addr == a && wb_mask[l]) r[l*32 +: 32] = wb_data[l*32 +: 32];
            else if (wa_en && wa_addr == a && wa_mask[l]) r[l*32 +: 32] = wa_data[l*32 +: 32];
            else r[l*32 +: 32] = mem[a][l];
         end
      return r;
   endfunction

   function automatic bit wr_now(input logic [3:0] a);
      return (wa_en && wa_addr == a) || (wb_en && wb_addr == a);
   endfunction

   function automatic logic [15:0] exp_busy();
      logic [15:0] b;
      for (int i = 0; i < 16; i++) b[i] = mbusy[i];
      return b;
   endfunction

   function automatic logic exp_src();
      logic [3:0] s [3];
      logic r;
      s[0] = ra; s[1] = rb; s[2] = rc;
      r = 1'b0;
      for (int j = 0; j < 3; j++) if (s[j] != 0 && mbusy[s[j]] && !wr_now(s[j])) r = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            mbusy[i] = 1'b0;
            for (int l = 0; l < 4; l++) mem[i][l] = '0;
         end
      end else begin
         for (int i = 1; i < 16; i++) begin
            for (int l = 0; l < 4; l++) mem[i][l] = exp_rd(4'(i))[l*32 +: 32];
            if (wr_now(4'(i))) mbusy[i] = 1'b0;
            if (iss_en && iss_rd == 4'(i)) mbusy[i] = 1'b1;
         end
      end
   end

   always @(negedge clk) if (started) begin
      chk("rd1", rd1, exp_rd(ra));
      chk("rd2", rd2, exp_rd(rb));
      chk("rd3", rd3, exp_rd(rc));
      chk("src_busy", {127'b0, src_busy}, {127'b0, exp_src()});
      chk("busy", {112'b0, busy}, {112'b0, exp_busy()});
   end

   task automatic idle();
      {wa_en, wb_en, iss_en} = '0;
      {wa_addr, wb_addr, iss_rd, ra, rb, rc} = '0;
      {wa_mask, wb_mask} = '0;
      wa_data = '0; wb_data = '0;
   endtask

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic randomize_inputs(input bit narrow);
      wa_en = $urandom_range(0, 1); wb_en = $urandom_range(0, 1); iss_en = $urandom_range(0, 1);
      wa_addr = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      wb_addr = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      iss_rd  = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      ra = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      rb = 4'($urandom); rc = 4'($urandom);
      wa_mask = 4'($urandom); wb_mask = 4'($urandom);
      for (int l = 0; l < 4; l++) begin
         wa_data[l*32 +: 32] = $urandom;
         wb_data[l*32 +: 32] = $urandom;
      end
   endtask

   initial begin
      idle();
      #45 rst = 1'b1;
      started = 1'b1;
      step();
      wa_en = 1'b1; wa_addr = 4'd3; wa_mask = 4'b0101;
      wa_data = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
      step(); idle(); ra = 4'd3; #1;
      chk("masked_write", rd1, {32'h0, 32'hCCCC_CCCC, 32'h0, 32'hAAAA_AAAA});
      wa_en = 1'b1; wa_addr = 4'd5; wa_mask = 4'b0011; wa_data = {4{32'h1111_1111}};
      wb_en = 1'b1; wb_addr = 4'd5; wb_mask = 4'b0110; wb_data = {4{32'h2222_2222}};
      step(); idle(); rb = 4'd5; #1;
      chk("collision", rd2, {32'h0, 32'h2222_2222, 32'h2222_2222, 32'h1111_1111});
      wb_en = 1'b1; wb_addr = 4'd7; wb_mask = 4'hF; wb_data = {4{32'hDEAD_BEEF}}; ra = 4'd7;
      wa_en = 1'b1; wa_addr = 4'd0; wa_mask = 4'hF; wa_data = {4{32'hFFFF_FFFF}}; rc = 4'd0; #1;
      chk("bypass", rd1, {4{32'hDEAD_BEEF}});
      chk("r0_bypass", rd3, '0);
      step(); idle(); ra = 4'd7; rc = 4'd0; #1;
      chk("bypass_commit", rd1, {4{32'hDEAD_BEEF}});
      chk("r0_read", rd3, '0);
      iss_en = 1'b1; iss_rd = 4'd9;
      step(); idle(); rb = 4'd9; #1;
      chk("sb_stall", {127'b0, src_busy}, 128'd1);
      chk("sb_set", {112'b0, busy}, 128'h0200);
      wa_en = 1'b1; wa_addr = 4'd9; wa_mask = 4'h0; #1;
      chk("sb_bypass", {127'b0, src_busy}, 128'd0);
      step(); idle(); #1;
      chk("sb_clear", {112'b0, busy}, 128'h0);
      iss_en = 1'b1; iss_rd = 4'd9; wa_en = 1'b1; wa_addr = 4'd9; wa_mask = 4'hF;
      step(); idle(); #1;
      chk("sb_set_wins", {112'b0, busy}, 128'h0200);
      iss_en = 1'b1; iss_rd = 4'd2;
      step(); idle(); ra = 4'd5; rb = 4'd3; rc = 4'd7; #1;
      chk("pre_reset_busy", {112'b0, busy}, 128'h0204);
      rst = 1'b0; #1;
      chk("async_busy", {112'b0, busy}, '0);
      chk("async_rd1", rd1, '0);
      chk("async_rd2", rd2, '0);
      chk("async_rd3", rd3, '0);
      rst = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         step();
         randomize_inputs(c % 3 == 0);
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         randomize_inputs(1'b0);
         ra = 4'(i); rb = 4'(i); rc = 4'(i); #1;
         chk("reset_rd", rd1 | rd2 | rd3, '0);
         chk("reset_busy", {111'b0, busy, src_busy}, '0);
         step();
      end
      idle();
      rst = 1'b1;
      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
